// File: rtl/lcd_cmd_driver.sv
// HD44780 command sequencer: turns strobe-toggled LCD words from the LSU into timed
// setup / enable-pulse / hold / execute bus cycles, with a one-deep pending buffer.
module lcd_cmd_driver #(
  parameter int unsigned T_SETUP_CYC = 3,
  parameter int unsigned T_PW_CYC    = 12,
  parameter int unsigned T_HOLD_CYC  = 2,
  parameter int unsigned T_EXEC_CYC  = 1850,
  parameter int unsigned T_LONG_CYC  = 76000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_io_lcd,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_lcd_blon,
  output logic [31:0] o_lcd_status
);

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StWait} state_e;

  localparam logic [CNT_W-1:0] SetupLd = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PwLd    = CNT_W'(T_PW_CYC - 1);
  localparam logic [CNT_W-1:0] HoldLd  = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] ExecLd  = CNT_W'(T_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LongLd  = CNT_W'(T_LONG_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Command words are {RS, RW, DATA[7:0]}.
  logic [9:0]       act_q, act_d;
  logic [9:0]       pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_stb_q, pend_stb_d;
  logic             ovf_q, ovf_d;
  logic             ack_q, ack_d;
  logic             strobe_q;
  logic             en_q, en_d;
  logic             on_q, blon_q;

  logic       new_cmd;
  logic [9:0] cmd_in;
  logic       phase_done;
  logic       act_long;
  logic       free;
  logic       ovf_set;

  assign new_cmd    = i_io_lcd[10] ^ strobe_q;
  assign cmd_in     = i_io_lcd[9:0];
  assign phase_done = (cnt_q == '0);
  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign act_long   = !act_q[9] && (act_q[7:2] == 6'd0) && (act_q[1:0] != 2'd0);
  assign free       = (state_q == StIdle) || ((state_q == StWait) && phase_done);

  always_comb begin
    state_d    = state_q;
    cnt_d      = phase_done ? cnt_q : cnt_q - CNT_W'(1);
    act_d      = act_q;
    ack_d      = ack_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    pend_stb_d = pend_stb_q;
    ovf_set    = 1'b0;

    case (state_q)
      StSetup: if (phase_done) begin
        state_d = StPulse;
        cnt_d   = PwLd;
      end
      StPulse: if (phase_done) begin
        state_d = StHold;
        cnt_d   = HoldLd;
      end
      StHold: if (phase_done) begin
        state_d = StWait;
        cnt_d   = act_long ? LongLd : ExecLd;
      end
      default: ;
    endcase

    if (free) begin
      if (pend_vld_q) begin
        state_d    = StSetup;
        cnt_d      = SetupLd;
        act_d      = pend_q;
        ack_d      = pend_stb_q;
        pend_vld_d = new_cmd;
        if (new_cmd) begin
          pend_d     = cmd_in;
          pend_stb_d = i_io_lcd[10];
        end
      end else if (new_cmd) begin
        state_d = StSetup;
        cnt_d   = SetupLd;
        act_d   = cmd_in;
        ack_d   = i_io_lcd[10];
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end else if (new_cmd) begin
      if (!pend_vld_q) begin
        pend_d     = cmd_in;
        pend_stb_d = i_io_lcd[10];
        pend_vld_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end

    // A held clear request wins over a same-cycle overflow.
    ovf_d = i_io_lcd[11] ? 1'b0 : (ovf_q | ovf_set);
    en_d  = (state_d == StPulse);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      pend_stb_q <= 1'b0;
      ovf_q      <= 1'b0;
      ack_q      <= 1'b0;
      strobe_q   <= 1'b0;
      en_q       <= 1'b0;
      on_q       <= 1'b0;
      blon_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      pend_stb_q <= pend_stb_d;
      ovf_q      <= ovf_d;
      ack_q      <= ack_d;
      strobe_q   <= i_io_lcd[10];
      en_q       <= en_d;
      on_q       <= i_io_lcd[31];
      blon_q     <= i_io_lcd[30];
    end
  end

  assign o_lcd_data   = act_q[7:0];
  assign o_lcd_rs     = act_q[9];
  assign o_lcd_rw     = act_q[8];
  assign o_lcd_en     = en_q;
  assign o_lcd_on     = on_q;
  assign o_lcd_blon   = blon_q;
  assign o_lcd_status = {28'd0, ack_q, ovf_q, pend_vld_q, (state_q != StIdle)};

endmodule

// File: tb/tb_lcd_cmd_driver.sv
// Bench for lcd_cmd_driver: directed scenarios with fixed expectations, then random
// command traffic against a timeline model of accepted commands.
module tb_lcd_cmd_driver;

  localparam int unsigned TS = 2;
  localparam int unsigned TP = 4;
  localparam int unsigned TH = 1;
  localparam int unsigned TE = 10;
  localparam int unsigned TL = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lcd_in = 32'h0;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
  logic [31:0] lcd_status;

  int checks = 0;
  int errors = 0;
  int en_rises = 0;
  logic prev_en = 1'b0;

  lcd_cmd_driver #(
    .T_SETUP_CYC(TS),
    .T_PW_CYC   (TP),
    .T_HOLD_CYC (TH),
    .T_EXEC_CYC (TE),
    .T_LONG_CYC (TL),
    .CNT_W      (17)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_io_lcd    (lcd_in),
    .o_lcd_data  (lcd_data),
    .o_lcd_rs    (lcd_rs),
    .o_lcd_rw    (lcd_rw),
    .o_lcd_en    (lcd_en),
    .o_lcd_on    (lcd_on),
    .o_lcd_blon  (lcd_blon),
    .o_lcd_status(lcd_status)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample 1 ns later; also counts EN rising edges.
  task automatic step();
    @(posedge clk);
    #1;
    if (lcd_en && !prev_en) en_rises++;
    prev_en = lcd_en;
  endtask

  // Reference model: one active command with a start cycle, plus at most one pending.
  int          m_t, m_start;
  bit          m_have, m_pend_vld, m_pend_stb, m_ovf, m_ack, m_prev, m_on, m_blon;
  logic [9:0]  m_act, m_pend, m_bus;

  function automatic int dur(input logic [9:0] c);
    bit lng;
    lng = (c[9] == 1'b0) && (c[7:0] >= 8'd1) && (c[7:0] <= 8'd3);
    return TS + TP + TH + (lng ? TL : TE);
  endfunction

  task automatic model_reset();
    m_t = 0; m_start = 0; m_have = 0; m_pend_vld = 0; m_pend_stb = 0;
    m_ovf = 0; m_ack = 0; m_prev = 0; m_on = 0; m_blon = 0;
    m_act = '0; m_pend = '0; m_bus = '0;
  endtask

  task automatic model_start(input logic [9:0] c, input bit s);
    m_have = 1; m_start = m_t; m_act = c; m_bus = c; m_ack = s;
  endtask

  task automatic model_edge(input logic [31:0] w);
    bit nw, ending, set;
    m_t++;
    nw     = (w[10] != m_prev);
    ending = m_have && ((m_t - m_start) == dur(m_act));
    set    = 0;
    if (!m_have || ending) begin
      if (m_pend_vld) begin
        model_start(m_pend, m_pend_stb);
        m_pend_vld = nw;
        if (nw) begin m_pend = w[9:0]; m_pend_stb = w[10]; end
      end else if (nw) begin
        model_start(w[9:0], w[10]);
      end else begin
        m_have = 0;
      end
    end else if (nw) begin
      if (!m_pend_vld) begin m_pend = w[9:0]; m_pend_stb = w[10]; m_pend_vld = 1; end
      else set = 1;
    end
    if (w[11]) m_ovf = 0;
    else if (set) m_ovf = 1;
    m_prev = w[10]; m_on = w[31]; m_blon = w[30];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lcd_in = 32'hC000_0000;
    step(); step();
    checks++;
    if ({lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, lcd_status} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h rs=%b rw=%b en=%b on=%b blon=%b st=%h want all 0",
               lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, lcd_status);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({lcd_on, lcd_blon, lcd_en} !== 3'b110 || lcd_status !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: got on=%b blon=%b en=%b st=%h want on=1 blon=1 en=0 st=0",
               lcd_on, lcd_blon, lcd_en, lcd_status);
    end
  endtask

  task automatic test_single();
    int rise, cnt, fall;
    rise = -1; cnt = 0; fall = -1;
    lcd_in = 32'h0000_0438;
    step();
    checks++;
    if (lcd_data !== 8'h38 || lcd_rs !== 1'b0 || lcd_status[0] !== 1'b1 || lcd_en !== 1'b0) begin
      errors++;
      $display("FAIL single_bus: got data=%h rs=%b busy=%b en=%b want 38 0 1 0",
               lcd_data, lcd_rs, lcd_status[0], lcd_en);
    end
    for (int i = 1; i <= 30; i++) begin
      step();
      if (lcd_en) begin cnt++; if (rise < 0) rise = i; end
      if (!lcd_status[0] && fall < 0) fall = i;
    end
    checks++;
    if (rise != TS || cnt != TP) begin
      errors++;
      $display("FAIL single_en: got rise=%0d width=%0d want rise=%0d width=%0d", rise, cnt, TS, TP);
    end
    checks++;
    if (fall != 17 || lcd_status[3] !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got fall=%0d ack=%b want fall=17 ack=1", fall, lcd_status[3]);
    end
  endtask

  task automatic test_clear();
    int fall;
    fall = -1;
    lcd_in = 32'h0000_0001;
    step();
    checks++;
    if (lcd_data !== 8'h01 || lcd_status[0] !== 1'b1 || lcd_status[3] !== 1'b0) begin
      errors++;
      $display("FAIL clear_start: got data=%h busy=%b ack=%b want 01 1 0",
               lcd_data, lcd_status[0], lcd_status[3]);
    end
    for (int i = 1; i <= 60; i++) begin
      step();
      if (!lcd_status[0] && fall < 0) fall = i;
    end
    checks++;
    if (fall != 47) begin
      errors++;
      $display("FAIL clear_busy: got busy_len=%0d want 47", fall);
    end
  endtask

  task automatic test_back_to_back();
    int r0, fall;
    logic [7:0] d16, d17;
    logic b17;
    fall = -1; d16 = '0; d17 = '0; b17 = 1'b0;
    r0 = en_rises;
    lcd_in = 32'h0000_0641;
    step(); step(); step();
    lcd_in = 32'h0000_0242;
    step();
    checks++;
    if (lcd_status[1] !== 1'b1 || lcd_data !== 8'h41) begin
      errors++;
      $display("FAIL b2b_pending: got pend=%b data=%h want pend=1 data=41", lcd_status[1], lcd_data);
    end
    for (int i = 4; i <= 60; i++) begin
      step();
      if (i == 16) d16 = lcd_data;
      if (i == 17) begin d17 = lcd_data; b17 = lcd_status[0]; end
      if (!lcd_status[0] && fall < 0) fall = i;
    end
    checks++;
    if (d16 !== 8'h41 || d17 !== 8'h42 || b17 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_handoff: got d16=%h d17=%h busy17=%b want 41 42 1", d16, d17, b17);
    end
    checks++;
    if (en_rises - r0 != 2 || fall != 34 || lcd_status[2] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulses: got pulses=%0d fall=%0d ovf=%b want 2 34 0",
               en_rises - r0, fall, lcd_status[2]);
    end
  endtask

  task automatic test_overflow();
    int r0, n;
    r0 = en_rises;
    lcd_in = 32'h0000_0630;
    step(); step();
    lcd_in = 32'h0000_0231;
    step(); step();
    lcd_in = 32'h0000_0632;
    step();
    checks++;
    if (lcd_status[2:1] !== 2'b11) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b pend=%b want 1 1", lcd_status[2], lcd_status[1]);
    end
    lcd_in = 32'h0000_0E32;
    step();
    checks++;
    if (lcd_status[2] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%b want 0", lcd_status[2]);
    end
    lcd_in = 32'h0000_0632;
    n = 0;
    while (lcd_status[0] && n < 100) begin step(); n++; end
    checks++;
    if (lcd_status[0] !== 1'b0 || en_rises - r0 != 2 || lcd_data !== 8'h31) begin
      errors++;
      $display("FAIL ovf_pulses: got busy=%b pulses=%0d data=%h want 0 2 31",
               lcd_status[0], en_rises - r0, lcd_data);
    end
  endtask

  task automatic test_reset_abort();
    int n, r0;
    bit seen_busy;
    n = 0; seen_busy = 0;
    lcd_in = 32'h0000_0255;
    step();
    while (!lcd_en && n < 10) begin step(); n++; end
    checks++;
    if (lcd_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_en_high: got en=%b want 1", lcd_en);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (lcd_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: got en=%b want 0", lcd_en);
    end
    lcd_in = 32'h0;
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if (lcd_status !== 32'h0) begin
      errors++;
      $display("FAIL abort_status: got st=%h want 0", lcd_status);
    end
    r0 = en_rises;
    for (int i = 0; i < 30; i++) begin
      step();
      if (lcd_status[0]) seen_busy = 1;
    end
    checks++;
    if (en_rises != r0 || seen_busy) begin
      errors++;
      $display("FAIL abort_reissue: got pulses=%0d busy_seen=%b want 0 0", en_rises - r0, seen_busy);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [51:0] got, exp;
    bit exp_en;
    int rate, rel;
    rst = 1'b1;
    lcd_in = 32'h0;
    step(); step();
    rst = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      model_edge(lcd_in);
      rel    = m_t - m_start;
      exp_en = m_have && (rel >= TS) && (rel < TS + TP);
      exp = {m_on, m_blon, exp_en, m_bus[9], m_bus[8], m_bus[7:0],
             28'd0, m_ack, m_ovf, m_pend_vld, m_have};
      got = {lcd_on, lcd_blon, lcd_en, lcd_rs, lcd_rw, lcd_data, lcd_status};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle %0d: got %h want %h", cyc, got, exp);
      end
      rate = (cyc < 1500) ? 6 : 30;
      w = lcd_in;
      if ($urandom % 16 == 0) w[31:30] = 2'($urandom);
      if ($urandom % rate == 0) begin
        w[10]  = ~w[10];
        w[9:8] = 2'($urandom);
        w[7:0] = 8'($urandom_range(1, 255));
        if ($urandom % 4 == 0) begin w[9] = 1'b0; w[7:0] = 8'($urandom_range(1, 3)); end
      end
      w[11] = ($urandom % 20 == 0);
      lcd_in = w;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_clear();
    test_back_to_back();
    test_overflow();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
